pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller that drives the hold and bubble inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It consumes ID/EX register outputs (dest, mem_read, reg_write), ID-stage source register IDs, the EX branch-redirect signal and the MEM-stage data-memory handshake. It resolves load-use hazards, multi-cycle data-memory waits and branch redirects. It also keeps saturating hazard performance counters and a sticky memory-timeout flag.

Parameters:
REG_ID_WIDTH, 5, width of register identifiers
CNT_WIDTH, 32, width of each performance counter
MAX_WAIT, 255, MEM_WAIT cycles tolerated before mem_timeout sets (valid range 1..2^16-1)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
id_reg1  input  REG_ID_WIDTH  rs1 of the instruction in ID
id_reg2  input  REG_ID_WIDTH  rs2 of the instruction in ID
id_uses_reg1  input  1  ID instruction reads rs1
id_uses_reg2  input  1  ID instruction reads rs2
ex_dest  input  REG_ID_WIDTH  dest_out of ID/EX
ex_mem_read  input  1  mem_control_out[1] of ID/EX
ex_reg_write  input  1  wb_control_out[1] of ID/EX
ex_redirect  input  1  branch/jump taken in EX this cycle
dmem_req  input  1  MEM stage has a load/store in flight
dmem_ready  input  1  data memory completes the access this cycle
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  load NOP into IF/ID
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  load bubble into ID/EX (all control bits 0)
ex_mem_stall  output  1  hold EX/MEM
mem_wb_bubble  output  1  load bubble into MEM/WB
load_use_cnt  output  CNT_WIDTH  load-use bubbles inserted
mem_wait_cnt  output  CNT_WIDTH  cycles frozen on data memory
flush_cnt  output  CNT_WIDTH  redirect flushes
mem_timeout  output  1  sticky: a single MEM_WAIT exceeded MAX_WAIT cycles

Behaviour:
- Reset: while reset=1, all stall/flush/bubble outputs are 0. On the edge with reset=1: state<=RUN, all counters<=0, wait_cnt<=0, mem_timeout<=0. Reset asserted mid-MEM_WAIT aborts the wait with no counter update.
- Conditions, all combinational from inputs:
  - mem_hold = dmem_req & ~dmem_ready.
  - lu_hit = ex_mem_read & ex_reg_write & (ex_dest!=0) & ((id_uses_reg1 & id_reg1==ex_dest) | (id_uses_reg2 & id_reg2==ex_dest)).
- Priority: mem_hold > ex_redirect > lu_hit. Exactly one action applies per cycle.
- mem_hold action: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_bubble = 1; flush outputs = 0. Redirect and load-use are ignored. The frozen EX instruction re-presents them after release.
- ex_redirect action (no mem_hold): if_id_flush = 1, id_ex_flush = 1; all stalls = 0. A simultaneous lu_hit is dropped, because the dependent instruction is flushed.
- lu_hit action (no mem_hold, no redirect): pc_stall = 1, if_id_stall = 1, id_ex_flush = 1. This inserts exactly one bubble. The next cycle the load is in MEM, so lu_hit deasserts naturally.
- FSM states RUN and MEM_WAIT:
  - RUN -> MEM_WAIT when mem_hold; wait_cnt <= 1.
  - MEM_WAIT stays while mem_hold; wait_cnt increments and saturates at MAX_WAIT+1.
  - MEM_WAIT -> RUN on the first cycle with dmem_ready=1 or dmem_req=0. That cycle has no freeze; the pipeline advances and normal priority applies. wait_cnt <= 0.
  - When wait_cnt reaches MAX_WAIT+1, mem_timeout <= 1 and stays set until reset. The stall continues; the timeout is flag only.
- Counters: increment by 1 on each clock edge whose cycle took the corresponding action. Counters saturate at all-ones and never wrap.
  - mem_wait_cnt counts every mem_hold cycle, including the RUN-state entry cycle.
  - flush_cnt counts redirect actions.
  - load_use_cnt counts lu_hit actions.
- Latency: all control outputs are combinational, same cycle. Counters and flags update one cycle later.

Test Plan:
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_dest=5, id_reg2=5, id_uses_reg2=1 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; load_use_cnt goes 0->1.
- x0 and unused-source filter: ex_dest=0 matching id_reg1=0; separately ex_dest=7, id_reg1=7, id_uses_reg1=0 -> no stall; counter unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles, then dmem_ready=1 -> full freeze plus mem_wb_bubble for exactly 4 cycles, release on cycle 5; mem_wait_cnt=4; state returns to RUN.
- Redirect during load-use: ex_redirect=1 with lu_hit=1 -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1, load_use_cnt=0.
- Redirect during memory freeze: mem_hold and ex_redirect both asserted for 3 cycles, then ready -> freeze only for 3 cycles, flushes on cycle 4; flush_cnt=1.
- Timeout and reset: MAX_WAIT=3, hold dmem_ready=0 for 6 cycles -> mem_timeout=1 after the 4th wait edge and stays set. Reset asserted mid-wait -> outputs 0 that cycle; counters and mem_timeout cleared the next cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: resolves data-memory waits, EX redirects and
// load-use hazards, and keeps saturating hazard counters plus a sticky timeout flag.
module pipeline_hazard_ctrl #(
  parameter int REG_ID_WIDTH = 5,
  parameter int CNT_WIDTH    = 32,
  parameter int MAX_WAIT     = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [REG_ID_WIDTH-1:0] id_reg1,
  input  logic [REG_ID_WIDTH-1:0] id_reg2,
  input  logic                    id_uses_reg1,
  input  logic                    id_uses_reg2,
  input  logic [REG_ID_WIDTH-1:0] ex_dest,
  input  logic                    ex_mem_read,
  input  logic                    ex_reg_write,
  input  logic                    ex_redirect,
  input  logic                    dmem_req,
  input  logic                    dmem_ready,
  output logic                    pc_stall,
  output logic                    if_id_stall,
  output logic                    if_id_flush,
  output logic                    id_ex_stall,
  output logic                    id_ex_flush,
  output logic                    ex_mem_stall,
  output logic                    mem_wb_bubble,
  output logic [CNT_WIDTH-1:0]    load_use_cnt,
  output logic [CNT_WIDTH-1:0]    mem_wait_cnt,
  output logic [CNT_WIDTH-1:0]    flush_cnt,
  output logic                    mem_timeout
);

  // 17 bits hold MAX_WAIT+1 for the largest legal MAX_WAIT (2^16-1).
  localparam int          WAIT_W     = 17;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT + 1);
  localparam int          NUM_CNT    = 3;

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  state_t              state_reg, state_next;
  logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic                timeout_reg, timeout_next;

  logic mem_hold;
  logic src1_hit;
  logic src2_hit;
  logic lu_hit;
  logic act_mem;
  logic act_redirect;
  logic act_lu;

  // Hazard detection and the single winning action for this cycle.
  always_comb begin
    mem_hold     = dmem_req & ~dmem_ready;
    src1_hit     = id_uses_reg1 & (id_reg1 == ex_dest);
    src2_hit     = id_uses_reg2 & (id_reg2 == ex_dest);
    lu_hit       = ex_mem_read & ex_reg_write & (ex_dest != '0) & (src1_hit | src2_hit);
    act_mem      = mem_hold;
    act_redirect = ~mem_hold & ex_redirect;
    act_lu       = ~mem_hold & ~ex_redirect & lu_hit;
  end

  always_comb begin
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!reset) begin
      if (act_mem) begin
        pc_stall      = 1'b1;
        if_id_stall   = 1'b1;
        id_ex_stall   = 1'b1;
        ex_mem_stall  = 1'b1;
        mem_wb_bubble = 1'b1;
      end else if (act_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (act_lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  // Wait tracker: counts consecutive frozen cycles, release cycle returns to RUN.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      ST_RUN: begin
        if (mem_hold) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_hold) begin
          if (wait_cnt_reg != WAIT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end else begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
    if (wait_cnt_next == WAIT_LIMIT) begin
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign mem_timeout = timeout_reg;

  // Saturating event counters: [0]=load-use, [1]=mem wait, [2]=flush.
  logic [NUM_CNT-1:0]   cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_reg [NUM_CNT];

  assign cnt_inc = {act_redirect, act_mem, act_lu};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg[gi];
        if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
          cnt_next = cnt_reg[gi] + CNT_WIDTH'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else begin
          cnt_reg[gi] <= cnt_next;
        end
      end
    end
  endgenerate

  assign load_use_cnt = cnt_reg[0];
  assign mem_wait_cnt = cnt_reg[1];
  assign flush_cnt    = cnt_reg[2];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with small counters and MAX_WAIT=3
// so that timeout and counter saturation are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_reg1, id_reg2, ex_dest;
  logic          id_uses_reg1, id_uses_reg2;
  logic          ex_mem_read, ex_reg_write, ex_redirect;
  logic          dmem_req, dmem_ready;
  logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic          ex_mem_stall, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] load_use_cnt, mem_wait_cnt, flush_cnt;

  int compared   = 0;
  int mismatched = 0;

  pipeline_hazard_ctrl #(
    .REG_ID_WIDTH(RW),
    .CNT_WIDTH   (CW),
    .MAX_WAIT    (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_reg1      (id_reg1),
    .id_reg2      (id_reg2),
    .id_uses_reg1 (id_uses_reg1),
    .id_uses_reg2 (id_uses_reg2),
    .ex_dest      (ex_dest),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_redirect  (ex_redirect),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_bubble(mem_wb_bubble),
    .load_use_cnt (load_use_cnt),
    .mem_wait_cnt (mem_wait_cnt),
    .flush_cnt    (flush_cnt),
    .mem_timeout  (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_reg1 = '0; id_reg2 = '0; ex_dest = '0;
    id_uses_reg1 = 1'b0; id_uses_reg2 = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_redirect = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd5;
    id_reg2 = 5'd5; id_uses_reg2 = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    dmem_req = 1'b1;
    ex_redirect = 1'b1;
    #1;
    chk("reset_pc_stall", pc_stall, 0);
    chk("reset_mem_wb_bubble", mem_wb_bubble, 0);
    chk("reset_if_id_flush", if_id_flush, 0);
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    chk("reset_load_use_cnt", load_use_cnt, 0);
    chk("reset_mem_wait_cnt", mem_wait_cnt, 0);
    chk("reset_flush_cnt", flush_cnt, 0);
    chk("reset_timeout", mem_timeout, 0);

    // Load-use hazard: one bubble.
    set_load_use();
    #1;
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_if_id_stall", if_id_stall, 1);
    chk("lu_id_ex_flush", id_ex_flush, 1);
    chk("lu_id_ex_stall", id_ex_stall, 0);
    chk("lu_if_id_flush", if_id_flush, 0);
    tick();
    idle_inputs();
    #1;
    chk("lu_release_pc_stall", pc_stall, 0);
    chk("lu_cnt", load_use_cnt, 1);

    // x0 destination and unused-source filtering.
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_dest = 5'd0;
    id_reg1 = 5'd0; id_uses_reg1 = 1'b1;
    #1;
    chk("x0_pc_stall", pc_stall, 0);
    tick();
    ex_dest = 5'd7; id_reg1 = 5'd7; id_uses_reg1 = 1'b0;
    #1;
    chk("unused_pc_stall", pc_stall, 0);
    chk("unused_id_ex_flush", id_ex_flush, 0);
    tick();
    chk("filter_lu_cnt", load_use_cnt, 1);
    idle_inputs();

    // Four-cycle memory wait; fourth edge reaches MAX_WAIT+1.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_pc_stall", pc_stall, 1);
      chk("mw_id_ex_stall", id_ex_stall, 1);
      chk("mw_ex_mem_stall", ex_mem_stall, 1);
      chk("mw_bubble", mem_wb_bubble, 1);
      if (i == 3) chk("mw_timeout_before", mem_timeout, 0);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_release_pc_stall", pc_stall, 0);
    chk("mw_release_bubble", mem_wb_bubble, 0);
    chk("mw_cnt", mem_wait_cnt, 4);
    chk("mw_timeout_after", mem_timeout, 1);
    tick();
    idle_inputs();
    #1;
    chk("mw_cnt_hold", mem_wait_cnt, 4);

    do_reset();
    #1;
    chk("reset2_timeout", mem_timeout, 0);
    chk("reset2_mw_cnt", mem_wait_cnt, 0);

    // Redirect beats load-use.
    set_load_use();
    ex_redirect = 1'b1;
    #1;
    chk("rd_lu_if_id_flush", if_id_flush, 1);
    chk("rd_lu_id_ex_flush", id_ex_flush, 1);
    chk("rd_lu_pc_stall", pc_stall, 0);
    chk("rd_lu_if_id_stall", if_id_stall, 0);
    tick();
    idle_inputs();
    #1;
    chk("rd_lu_flush_cnt", flush_cnt, 1);
    chk("rd_lu_lu_cnt", load_use_cnt, 0);

    // Redirect during memory freeze: freeze wins, flush on release cycle.
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rdmw_pc_stall", pc_stall, 1);
      chk("rdmw_if_id_flush", if_id_flush, 0);
      chk("rdmw_id_ex_flush", id_ex_flush, 0);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("rdmw_rel_if_id_flush", if_id_flush, 1);
    chk("rdmw_rel_pc_stall", pc_stall, 0);
    tick();
    idle_inputs();
    #1;
    chk("rdmw_flush_cnt", flush_cnt, 2);
    chk("rdmw_mw_cnt", mem_wait_cnt, 3);
    chk("rdmw_timeout", mem_timeout, 0);

    // Timeout then reset mid-wait.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("to_flag_edge%0d", i), mem_timeout, (i >= 4) ? 1 : 0);
    end
    chk("to_mw_cnt", mem_wait_cnt, 6);
    reset = 1'b1;
    #1;
    chk("to_reset_pc_stall", pc_stall, 0);
    chk("to_reset_bubble", mem_wb_bubble, 0);
    tick();
    reset = 1'b0;
    dmem_req = 1'b0;
    #1;
    chk("to_cleared_timeout", mem_timeout, 0);
    chk("to_cleared_mw_cnt", mem_wait_cnt, 0);

    // Fresh wait after reset restarts from 1: three edges stay below limit.
    dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("restart_timeout", mem_timeout, 0);
    chk("restart_mw_cnt", mem_wait_cnt, 3);

    // Counter saturation at all-ones.
    for (int i = 0; i < 14; i++) tick();
    chk("sat_mw_cnt", mem_wait_cnt, 15);
    tick();
    chk("sat_mw_cnt_hold", mem_wait_cnt, 15);
    chk("sat_timeout", mem_timeout, 1);
    idle_inputs();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
